// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the on-chip RV32IM program encoder.
// The optional M-extension encodings are enabled with the ENCODER_MULDIV_EN macro.
package instr_encoder_pkg;

    // Mnemonic selector carried on the command stream
    typedef enum logic [5:0] {
        ENC_LUI   = 6'd0,  ENC_AUIPC = 6'd1,  ENC_JAL   = 6'd2,  ENC_JALR  = 6'd3,
        ENC_BEQ   = 6'd4,  ENC_BNE   = 6'd5,  ENC_BLT   = 6'd6,  ENC_BGE   = 6'd7,
        ENC_BLTU  = 6'd8,  ENC_BGEU  = 6'd9,  ENC_LB    = 6'd10, ENC_LH    = 6'd11,
        ENC_LW    = 6'd12, ENC_LBU   = 6'd13, ENC_LHU   = 6'd14, ENC_SB    = 6'd15,
        ENC_SH    = 6'd16, ENC_SW    = 6'd17, ENC_ADDI  = 6'd18, ENC_SLTI  = 6'd19,
        ENC_SLTIU = 6'd20, ENC_XORI  = 6'd21, ENC_ORI   = 6'd22, ENC_ANDI  = 6'd23,
        ENC_SLLI  = 6'd24, ENC_SRLI  = 6'd25, ENC_SRAI  = 6'd26, ENC_ADD   = 6'd27,
        ENC_SUB   = 6'd28, ENC_SLL   = 6'd29, ENC_SLT   = 6'd30, ENC_SLTU  = 6'd31,
        ENC_XOR   = 6'd32, ENC_SRL   = 6'd33, ENC_SRA   = 6'd34, ENC_OR    = 6'd35,
        ENC_AND   = 6'd36, ENC_MUL   = 6'd37, ENC_MULH  = 6'd38, ENC_DIV   = 6'd39,
        ENC_DIVU  = 6'd40, ENC_REM   = 6'd41, ENC_REMU  = 6'd42
    } enc_op_t;

    // Major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_HALT   = 7'b1111111;

    // funct3 values (ALU, branch, load/store, M-extension share the 3-bit space)
    localparam logic [2:0] F3_ADD  = 3'b000, F3_SLL  = 3'b001, F3_SLT  = 3'b010, F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100, F3_SR   = 3'b101, F3_OR   = 3'b110, F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000, F3_BNE  = 3'b001, F3_BLT  = 3'b100, F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110, F3_BGEU = 3'b111;
    localparam logic [2:0] F3_B    = 3'b000, F3_H    = 3'b001, F3_W    = 3'b010;
    localparam logic [2:0] F3_BU   = 3'b100, F3_HU   = 3'b101;
    localparam logic [2:0] F3_MUL  = 3'b000, F3_MULH = 3'b001, F3_DIV  = 3'b100, F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110, F3_REMU = 3'b111;

    // funct7 values
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Default terminator and filler words
    localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] DEF_NOP_WORD  = 32'h0000_0013;

    // Instruction format packers
    function automatic logic [31:0] pack_r(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] pack_i(input logic [31:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] opc);
        return {imm[11:0], rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] pack_s(input logic [31:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] pack_b(input logic [31:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
    endfunction

    function automatic logic [31:0] pack_u(input logic [31:0] imm, input logic [4:0] rd,
                                           input logic [6:0] opc);
        return {imm[31:12], rd, opc};
    endfunction

    function automatic logic [31:0] pack_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field-to-word assembler for RV32I (plus RV32M when
// ENCODER_MULDIV_EN is defined). Flags ops it cannot encode.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  enc_op_t     op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        supported
);

    // Select the format and function codes for the requested mnemonic
    always_comb begin
        word      = 32'h0000_0000;
        supported = 1'b1;
        case (op)
            ENC_LUI:   word = pack_u(imm, rd, OP_LUI);
            ENC_AUIPC: word = pack_u(imm, rd, OP_AUIPC);
            ENC_JAL:   word = pack_j(imm, rd);
            ENC_JALR:  word = pack_i(imm, rs1, F3_ADD, rd, OP_JALR);
            ENC_BEQ:   word = pack_b(imm, rs2, rs1, F3_BEQ);
            ENC_BNE:   word = pack_b(imm, rs2, rs1, F3_BNE);
            ENC_BLT:   word = pack_b(imm, rs2, rs1, F3_BLT);
            ENC_BGE:   word = pack_b(imm, rs2, rs1, F3_BGE);
            ENC_BLTU:  word = pack_b(imm, rs2, rs1, F3_BLTU);
            ENC_BGEU:  word = pack_b(imm, rs2, rs1, F3_BGEU);
            ENC_LB:    word = pack_i(imm, rs1, F3_B, rd, OP_LOAD);
            ENC_LH:    word = pack_i(imm, rs1, F3_H, rd, OP_LOAD);
            ENC_LW:    word = pack_i(imm, rs1, F3_W, rd, OP_LOAD);
            ENC_LBU:   word = pack_i(imm, rs1, F3_BU, rd, OP_LOAD);
            ENC_LHU:   word = pack_i(imm, rs1, F3_HU, rd, OP_LOAD);
            ENC_SB:    word = pack_s(imm, rs2, rs1, F3_B);
            ENC_SH:    word = pack_s(imm, rs2, rs1, F3_H);
            ENC_SW:    word = pack_s(imm, rs2, rs1, F3_W);
            ENC_ADDI:  word = pack_i(imm, rs1, F3_ADD, rd, OP_I);
            ENC_SLTI:  word = pack_i(imm, rs1, F3_SLT, rd, OP_I);
            ENC_SLTIU: word = pack_i(imm, rs1, F3_SLTU, rd, OP_I);
            ENC_XORI:  word = pack_i(imm, rs1, F3_XOR, rd, OP_I);
            ENC_ORI:   word = pack_i(imm, rs1, F3_OR, rd, OP_I);
            ENC_ANDI:  word = pack_i(imm, rs1, F3_AND, rd, OP_I);
            // Shift-immediates reuse the R layout with shamt in the rs2 slot
            ENC_SLLI:  word = pack_r(F7_BASE, imm[4:0], rs1, F3_SLL, rd, OP_I);
            ENC_SRLI:  word = pack_r(F7_BASE, imm[4:0], rs1, F3_SR, rd, OP_I);
            ENC_SRAI:  word = pack_r(F7_ALT, imm[4:0], rs1, F3_SR, rd, OP_I);
            ENC_ADD:   word = pack_r(F7_BASE, rs2, rs1, F3_ADD, rd, OP_R);
            ENC_SUB:   word = pack_r(F7_ALT, rs2, rs1, F3_ADD, rd, OP_R);
            ENC_SLL:   word = pack_r(F7_BASE, rs2, rs1, F3_SLL, rd, OP_R);
            ENC_SLT:   word = pack_r(F7_BASE, rs2, rs1, F3_SLT, rd, OP_R);
            ENC_SLTU:  word = pack_r(F7_BASE, rs2, rs1, F3_SLTU, rd, OP_R);
            ENC_XOR:   word = pack_r(F7_BASE, rs2, rs1, F3_XOR, rd, OP_R);
            ENC_SRL:   word = pack_r(F7_BASE, rs2, rs1, F3_SR, rd, OP_R);
            ENC_SRA:   word = pack_r(F7_ALT, rs2, rs1, F3_SR, rd, OP_R);
            ENC_OR:    word = pack_r(F7_BASE, rs2, rs1, F3_OR, rd, OP_R);
            ENC_AND:   word = pack_r(F7_BASE, rs2, rs1, F3_AND, rd, OP_R);
`ifdef ENCODER_MULDIV_EN
            ENC_MUL:   word = pack_r(F7_MULDIV, rs2, rs1, F3_MUL, rd, OP_R);
            ENC_MULH:  word = pack_r(F7_MULDIV, rs2, rs1, F3_MULH, rd, OP_R);
            ENC_DIV:   word = pack_r(F7_MULDIV, rs2, rs1, F3_DIV, rd, OP_R);
            ENC_DIVU:  word = pack_r(F7_MULDIV, rs2, rs1, F3_DIVU, rd, OP_R);
            ENC_REM:   word = pack_r(F7_MULDIV, rs2, rs1, F3_REM, rd, OP_R);
            ENC_REMU:  word = pack_r(F7_MULDIV, rs2, rs1, F3_REMU, rd, OP_R);
`else
            // Without the M extension these mnemonics fall through to default
`endif
            default: begin
                word      = 32'h0000_0000;
                supported = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded RV32IM words into instruction memory and terminates the
// program with HALT_WORD. Optional M-extension: define ENCODER_MULDIV_EN.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned IMEM_ADDR_W = 10,
    parameter logic [31:0] HALT_WORD   = DEF_HALT_WORD,
    parameter logic [31:0] NOP_WORD    = DEF_NOP_WORD
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  enc_op_t                in_op,
    input  logic [4:0]             in_rd,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic [31:0]            in_imm,
    input  logic                   in_last,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_wdata,
    output logic                   done,
    output logic                   error,
    output logic [IMEM_ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALT_WR = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // The top slot is kept free so HALT always fits
    localparam logic [IMEM_ADDR_W-1:0] LAST_ADDR = {IMEM_ADDR_W{1'b1}};
    localparam logic [IMEM_ADDR_W-1:0] ADDR_ONE  = IMEM_ADDR_W'(1);
    localparam logic [IMEM_ADDR_W:0]   CNT_ONE   = (IMEM_ADDR_W + 1)'(1);

    state_t                 state_r,  state_nx_s;
    logic [IMEM_ADDR_W-1:0] addr_r,   addr_nx_s;
    logic                   we_r,     we_nx_s;
    logic [IMEM_ADDR_W-1:0] waddr_r,  waddr_nx_s;
    logic [31:0]            wdata_r,  wdata_nx_s;
    logic                   done_r,   done_nx_s;
    logic                   error_r,  error_nx_s;
    logic [IMEM_ADDR_W:0]   count_r,  count_nx_s;

    logic [31:0]            packed_word_s;
    logic                   packed_ok_s;
    logic                   accept_s;
    logic [IMEM_ADDR_W-1:0] addr_inc_s;

    instr_pack u_pack (
        .op        (in_op),
        .rd        (in_rd),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .imm       (in_imm),
        .word      (packed_word_s),
        .supported (packed_ok_s)
    );

    assign in_ready   = (state_r == ST_RUN) && (addr_r != LAST_ADDR);
    assign accept_s   = in_valid && in_ready;
    assign addr_inc_s = addr_r + ADDR_ONE;

    assign imem_we    = we_r;
    assign imem_addr  = waddr_r;
    assign imem_wdata = wdata_r;
    assign done       = done_r;
    assign error      = error_r;
    assign count      = count_r;

    // Next-state, write-port and flag computation
    always_comb begin
        state_nx_s = state_r;
        addr_nx_s  = addr_r;
        we_nx_s    = 1'b0;
        waddr_nx_s = waddr_r;
        wdata_nx_s = wdata_r;
        done_nx_s  = done_r;
        error_nx_s = error_r;
        count_nx_s = count_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nx_s = ST_RUN;
                    addr_nx_s  = '0;
                    done_nx_s  = 1'b0;
                    error_nx_s = 1'b0;
                    count_nx_s = '0;
                end else begin
                    done_nx_s  = (state_r == ST_DONE);
                end
            end
            ST_RUN: begin
                if (start) begin
                    // Restart wins over any beat presented this cycle
                    addr_nx_s  = '0;
                    done_nx_s  = 1'b0;
                    error_nx_s = 1'b0;
                    count_nx_s = '0;
                end else if (accept_s) begin
                    we_nx_s    = 1'b1;
                    waddr_nx_s = addr_r;
                    wdata_nx_s = packed_ok_s ? packed_word_s : NOP_WORD;
                    addr_nx_s  = addr_inc_s;
                    count_nx_s = count_r + CNT_ONE;
                    if (in_last) begin
                        state_nx_s = ST_HALT_WR;
                        error_nx_s = error_r | ~packed_ok_s;
                    end else if (addr_inc_s == LAST_ADDR) begin
                        // Program did not fit: stop and reserve the last slot for HALT
                        state_nx_s = ST_HALT_WR;
                        error_nx_s = 1'b1;
                    end else begin
                        error_nx_s = error_r | ~packed_ok_s;
                    end
                end else if (addr_r == LAST_ADDR) begin
                    state_nx_s = ST_HALT_WR;
                    error_nx_s = 1'b1;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_HALT_WR: begin
                we_nx_s    = 1'b1;
                waddr_nx_s = addr_r;
                wdata_nx_s = HALT_WORD;
                addr_nx_s  = addr_inc_s;
                count_nx_s = count_r + CNT_ONE;
                state_nx_s = ST_DONE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            addr_r  <= '0;
            we_r    <= 1'b0;
            waddr_r <= '0;
            wdata_r <= 32'h0000_0000;
            done_r  <= 1'b0;
            error_r <= 1'b0;
            count_r <= '0;
        end else begin
            state_r <= state_nx_s;
            addr_r  <= addr_nx_s;
            we_r    <= we_nx_s;
            waddr_r <= waddr_nx_s;
            wdata_r <= wdata_nx_s;
            done_r  <= done_nx_s;
            error_r <= error_nx_s;
            count_r <= count_nx_s;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (default and 2-bit address instances).
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        in_valid = 1'b0;
    enc_op_t     in_op = ENC_ADDI;
    logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
    logic [31:0] in_imm = 32'h0;
    logic        in_last = 1'b0;

    logic        in_ready, imem_we, done, error;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [10:0] count;

    logic        in_ready2, imem_we2, done2, error2;
    logic [1:0]  imem_addr2;
    logic [31:0] imem_wdata2;
    logic [2:0]  count2;

    logic [31:0] mem [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .done(done), .error(error), .count(count)
    );

    instr_encoder #(.IMEM_ADDR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
        .done(done2), .error(error2), .count(count2)
    );

    // Memory image as seen on the write port of the main instance
    always @(posedge clk) begin
        if (imem_we) mem[imem_addr] <= imem_wdata;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input enc_op_t op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic last);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_imm = imm; in_last = last;
    endtask

    task automatic pulse_start;
        start = 1'b1; tick; start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; tick; tick;
        n_tests++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, done, error, count} !== 56'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b we=%b a=%h d=%h dn=%b er=%b c=%0d want all 0",
                     in_ready, imem_we, imem_addr, imem_wdata, done, error, count);
        end
        n_tests++;
        if ({in_ready2, imem_we2, done2, error2, count2} !== 7'h0) begin
            n_fail++;
            $display("FAIL reset_outputs2: got rdy=%b we=%b dn=%b er=%b c=%0d want all 0",
                     in_ready2, imem_we2, done2, error2, count2);
        end
        rst_n = 1'b1; tick;
    endtask

    task automatic test_single_addi;
        pulse_start;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_start: got %b want 1", in_ready); end
        beat(ENC_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        tick;
        in_valid = 1'b0; in_last = 1'b0;
        n_tests++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd0, 32'h00500093}) begin
            n_fail++; $display("FAIL addi_word: got we=%b a=%0d d=%h want 1/0/00500093", imem_we, imem_addr, imem_wdata);
        end
        tick;
        n_tests++;
        if ({imem_we, imem_addr, imem_wdata, done} !== {1'b1, 10'd1, 32'hFFFFFFFF, 1'b0}) begin
            n_fail++; $display("FAIL addi_halt: got we=%b a=%0d d=%h done=%b want 1/1/ffffffff/0", imem_we, imem_addr, imem_wdata, done);
        end
        tick;
        n_tests++;
        if ({done, count, error, imem_we} !== {1'b1, 11'd2, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL addi_done: got done=%b count=%0d err=%b we=%b want 1/2/0/0", done, count, error, imem_we);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp [3];
        exp[0] = 32'h002081B3; exp[1] = 32'h0020A423; exp[2] = 32'h00208463;
        pulse_start;
        beat(ENC_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        tick;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) beat(ENC_SW, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
            else if (i == 1) beat(ENC_BEQ, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1);
            else begin in_valid = 1'b0; in_last = 1'b0; end
            n_tests++;
            if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'(i), exp[i]}) begin
                n_fail++; $display("FAIL b2b_word%0d: got we=%b a=%0d d=%h want 1/%0d/%h", i, imem_we, imem_addr, imem_wdata, i, exp[i]);
            end
            tick;
        end
        n_tests++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd3, 32'hFFFFFFFF}) begin
            n_fail++; $display("FAIL b2b_halt: got we=%b a=%0d d=%h want 1/3/ffffffff", imem_we, imem_addr, imem_wdata);
        end
        tick;
        n_tests++;
        if ({done, count} !== {1'b1, 11'd4}) begin
            n_fail++; $display("FAIL b2b_done: got done=%b count=%0d want 1/4", done, count);
        end
    endtask

    task automatic test_jal_lui;
        pulse_start;
        beat(ENC_JAL, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0);
        tick;
        beat(ENC_LUI, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1);
        n_tests++;
        if (imem_wdata !== 32'h010000EF) begin n_fail++; $display("FAIL jal_word: got %h want 010000ef", imem_wdata); end
        tick;
        in_valid = 1'b0; in_last = 1'b0;
        n_tests++;
        if ({imem_addr, imem_wdata} !== {10'd1, 32'h123452B7}) begin
            n_fail++; $display("FAIL lui_word: got a=%0d d=%h want 1/123452b7", imem_addr, imem_wdata);
        end
        tick; tick;
    endtask

    task automatic test_muldiv;
        logic [31:0] exp_w;
        logic        exp_e;
`ifdef ENCODER_MULDIV_EN
        exp_w = 32'h022081B3; exp_e = 1'b0;
`else
        exp_w = 32'h00000013; exp_e = 1'b1;
`endif
        pulse_start;
        beat(ENC_MUL, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        tick;
        in_valid = 1'b0; in_last = 1'b0;
        n_tests++;
        if (imem_wdata !== exp_w) begin n_fail++; $display("FAIL mul_word: got %h want %h", imem_wdata, exp_w); end
        tick; tick;
        n_tests++;
        if ({done, error} !== {1'b1, exp_e}) begin
            n_fail++; $display("FAIL mul_error: got done=%b err=%b want 1/%b", done, error, exp_e);
        end
    endtask

    task automatic test_unsupported_restart;
        pulse_start;
        beat(enc_op_t'(6'h3F), 5'd1, 5'd0, 5'd0, 32'd0, 1'b0);
        tick;
        beat(ENC_ADDI, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0);
        n_tests++;
        if ({imem_wdata, error} !== {32'h00000013, 1'b1}) begin
            n_fail++; $display("FAIL bad_op_nop: got d=%h err=%b want 00000013/1", imem_wdata, error);
        end
        tick;
        n_tests++;
        if ({imem_addr, imem_wdata} !== {10'd1, 32'h00200113}) begin
            n_fail++; $display("FAIL bad_op_continue: got a=%0d d=%h want 1/00200113", imem_addr, imem_wdata);
        end
        start = 1'b1;
        beat(ENC_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        tick;
        start = 1'b0;
        n_tests++;
        if ({imem_we, error, count, in_ready} !== {1'b0, 1'b0, 11'd0, 1'b1}) begin
            n_fail++; $display("FAIL restart_discard: got we=%b err=%b c=%0d rdy=%b want 0/0/0/1", imem_we, error, count, in_ready);
        end
        tick;
        in_valid = 1'b0; in_last = 1'b0;
        n_tests++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd0, 32'h00500093}) begin
            n_fail++; $display("FAIL restart_addr0: got we=%b a=%0d d=%h want 1/0/00500093", imem_we, imem_addr, imem_wdata);
        end
        tick; tick;
        n_tests++;
        if ({done, error, count} !== {1'b1, 1'b0, 11'd2}) begin
            n_fail++; $display("FAIL restart_done: got done=%b err=%b c=%0d want 1/0/2", done, error, count);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] exp [3];
        exp[0] = 32'h00100093; exp[1] = 32'h00200113; exp[2] = 32'h00300193;
        start2 = 1'b1; tick; start2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            beat(ENC_ADDI, 5'(i + 1), 5'd0, 5'd0, 32'(i + 1), 1'b0);
            tick;
            if (i < 3) begin
                n_tests++;
                if ({imem_we2, imem_addr2, imem_wdata2} !== {1'b1, 2'(i), exp[i]}) begin
                    n_fail++; $display("FAIL ovf_word%0d: got we=%b a=%0d d=%h want 1/%0d/%h", i, imem_we2, imem_addr2, imem_wdata2, i, exp[i]);
                end
            end else if (i == 3) begin
                n_tests++;
                if ({imem_we2, imem_addr2, imem_wdata2} !== {1'b1, 2'd3, 32'hFFFFFFFF}) begin
                    n_fail++; $display("FAIL ovf_halt: got we=%b a=%0d d=%h want 1/3/ffffffff", imem_we2, imem_addr2, imem_wdata2);
                end
            end else begin
                n_tests++;
                if ({done2, error2, count2, imem_we2} !== {1'b1, 1'b1, 3'd4, 1'b0}) begin
                    n_fail++; $display("FAIL ovf_done: got done=%b err=%b c=%0d we=%b want 1/1/4/0", done2, error2, count2, imem_we2);
                end
            end
            if (i == 2) begin
                n_tests++;
                if (in_ready2 !== 1'b0) begin n_fail++; $display("FAIL ovf_ready: got %b want 0", in_ready2); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream;
        pulse_start;
        beat(ENC_ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
        tick;
        beat(ENC_ADDI, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0);
        tick;
        rst_n = 1'b0;
        tick;
        n_tests++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, done, error, count} !== 56'h0) begin
            n_fail++; $display("FAIL midreset_outputs: got rdy=%b we=%b a=%h d=%h dn=%b er=%b c=%0d want all 0",
                                in_ready, imem_we, imem_addr, imem_wdata, done, error, count);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        tick;
        n_tests++;
        if ({imem_we, mem[0], mem[1]} !== {1'b0, 32'h00100093, 32'h00200113}) begin
            n_fail++; $display("FAIL midreset_mem: got we=%b m0=%h m1=%h want 0/00100093/00200113", imem_we, mem[0], mem[1]);
        end
        pulse_start;
        beat(ENC_ADDI, 5'd5, 5'd0, 5'd0, 32'd5, 1'b1);
        tick;
        in_valid = 1'b0; in_last = 1'b0;
        n_tests++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd0, 32'h00500293}) begin
            n_fail++; $display("FAIL midreset_restart: got we=%b a=%0d d=%h want 1/0/00500293", imem_we, imem_addr, imem_wdata);
        end
        tick; tick;
    endtask

    initial begin
        test_reset;
        test_single_addi;
        test_back_to_back;
        test_jal_lui;
        test_muldiv;
        test_unsupported_restart;
        test_overflow;
        test_reset_midstream;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Assembles RV32IM machine words from a field-level command stream (op, rd, rs1, rs2, imm).
- Writes them sequentially into instruction memory, then appends the HALT word.
- It is the encode-side counterpart of the pipeline's instruction decoder: it drives the program-load port of instruction memory and is used by the self-test/boot path so programs can be generated on-chip without an external assembler.

## Interface
Parameters:
- IMEM_ADDR_W, 10 — word-address width of instruction memory.
- HALT_WORD, 32'hFFFF_FFFF — word appended after the last instruction (opcode 7'b1111111).
- NOP_WORD, 32'h0000_0013 — substituted for unsupported ops (ADDI x0,x0,0).

Ports:
- clk  in  1  — single clock.
- rst_n  in  1  — reset is synchronous and active-low.
- start  in  1  — one-cycle pulse: clear address/flags, enter RUN.
- in_valid  in  1  — command beat valid.
- in_ready  out  1  — encoder accepts beat this cycle.
- in_op  in  enc_op_t (6)  — mnemonic selector.
- in_rd / in_rs1 / in_rs2  in  5 each  — register indices.
- in_imm  in  32  — byte-offset/immediate, sign-extended form.
- in_last  in  1  — beat is final instruction.
- imem_we  out  1  — write strobe.
- imem_addr  out  IMEM_ADDR_W  — word address.
- imem_wdata  out  32  — encoded word.
- done  out  1  — level, program plus HALT written.
- error  out  1  — sticky: unsupported op or overflow.
- count  out  IMEM_ADDR_W+1  — words written including HALT.

## Operation
- FSM states:
  - IDLE → RUN on start.
  - RUN → HALT_WR when in_last is accepted, or when the address counter reaches 2^IMEM_ADDR_W−1. On reaching the last slot, set error (overflow); that slot is reserved for HALT.
  - HALT_WR → DONE after one cycle.
  - DONE → RUN on start.
- in_ready = 1 only in RUN and only while the address is below the last slot.
- Handshake: transfer when in_valid && in_ready. The beat is encoded combinationally and registered into imem_wdata with imem_we=1 on the next cycle. The address post-increments.
- Immediate packing:
  - I-type: imm[11:0].
  - S-type: imm[11:5] → [31:25], imm[4:0] → [11:7].
  - B-type: imm[12|10:5|4:1|11].
  - U-type: imm[31:12].
  - J-type: imm[20|10:1|11|19:12].
  - Shifts: shamt = imm[4:0]; SRAI uses funct7 0100000.
- Immediate bits outside the field are ignored; no range error.
- Unsupported in_op: write NOP_WORD in its slot and set error. The stream continues.
- start while in RUN: restart at address 0 and clear error/count. A beat accepted that same cycle is discarded.
- start takes priority over a simultaneous in_last.

## Timing
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, error=0, count=0.
- Throughput: one word per cycle.
- Latency: accept at cycle N → imem_we at N+1.
- HALT_WORD is written at the address following the last instruction, in the cycle after that instruction's write. done rises the cycle after the HALT write.
- Reset asserted mid-stream: return to IDLE at the next edge. No further writes occur; partial memory contents are left as written.

## Configuration
- ENCODER_MULDIV_EN defined: MUL, MULH, DIV, DIVU, REM, REMU encode with funct7 0000001.
- Undefined: those ops are treated as unsupported (NOP_WORD written, error set).

## Structure
- Shared package holds:
  - enc_op_t enum.
  - Opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_HALT).
  - funct3/funct7 constants.
  - HALT/NOP words.
- One sub-module, instr_pack: purely combinational op/fields → 32-bit word plus a supported flag. The top level holds the FSM, counter and output registers.

## Test plan
- start, then ADDI rd=1 rs1=0 imm=5 with in_last → addr0=0x00500093, addr1=HALT_WORD, done=1, count=2.
- Back-to-back ADD x3,x1,x2; SW x2,8(x1); BEQ x1,x2,+8 with in_valid held → 0x002081B3, 0x0020A423, 0x00208463 on consecutive cycles at addr 0..2.
- JAL x1,+16; LUI x5,0x12345000 → 0x010000EF, 0x123452B7.
- MUL x3,x1,x2:
  - with ENCODER_MULDIV_EN → 0x022081B3, error=0.
  - without → 0x00000013, error=1.
- IMEM_ADDR_W=2, stream 5 beats → 3 instructions written, in_ready drops, HALT at addr3, error=1, done=1.
- rst_n low during RUN at addr 2 → next cycle all outputs at reset values; start then reissues writes from addr0.
